omega_ramp_ctrl: RTL and testbench
==================================

OMEGA_RAMP_CTRL -- requirements
Module: omega_ramp_ctrl

Interface
REQ-001 SHALL have parameter OMEGA_BW, default 16: width of signed omega command.
REQ-002 SHALL have parameter RATE_BW, default 8: width of unsigned per-tick step size.
REQ-003 SHALL have parameter TICK_DIV, default 1024: clk cycles per ramp tick, at least 2.
REQ-004 SHALL have parameter DWELL, default 256: clk cycles held at zero during direction reversal, at least 1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  new target/rate offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_target  input  OMEGA_BW signed  requested final omega.
REQ-010 SHALL have port cmd_rate  input  RATE_BW unsigned  magnitude step per tick.
REQ-011 SHALL have port stop  input  1  level request to ramp omega to zero.
REQ-012 SHALL have port omega  output  OMEGA_BW signed  registered frequency word for the three-phase generator.
REQ-013 SHALL have port at_target  output  1  omega equals latched target; state is IDLE or HOLD.
REQ-014 SHALL have port busy  output  1  state is RAMP or DWELL.

Function
REQ-015 SHALL implement FSM states IDLE, RAMP, DWELL, HOLD.
REQ-016 SHALL run a free-running prescaler 0..TICK_DIV-1 that pulses tick for one cycle at count TICK_DIV-1 and then wraps to 0.
REQ-017 SHALL drive cmd_ready = !stop && state != DWELL, combinationally from registered state.
REQ-018 SHALL on accept latch the target and rate and enter RAMP next cycle; accept is allowed in IDLE, RAMP (retarget) and HOLD.
REQ-019 SHALL treat cmd_rate = 0 as 1.
REQ-020 SHALL clamp cmd_target = -2^(OMEGA_BW-1) to -(2^(OMEGA_BW-1)-1), so omega range is symmetric.
REQ-021 SHALL, while stop = 1, force latched target to 0, keep latched rate, enter RAMP if omega != 0, and ignore cmd_valid; stop has priority over a simultaneous cmd.
REQ-022 SHALL update omega in RAMP only on tick cycles, with the result registered.
REQ-023 SHALL, on a RAMP tick with d = target - omega computed in OMEGA_BW+1 bits: if |d| <= rate, set omega = target and go to HOLD, or to IDLE if target = 0.
REQ-024 SHALL, on a RAMP tick where |d| > rate, set omega = omega + sign(d)*rate.
REQ-025 SHALL, if a step would make omega zero or opposite in sign to a nonzero omega while target has the opposite sign, instead set omega = 0 and enter DWELL.
REQ-026 SHALL in DWELL count DWELL clk cycles (not ticks) and then return to RAMP; omega stays 0 throughout.
REQ-027 SHALL leave omega unchanged in IDLE, HOLD and DWELL.
REQ-028 SHALL never allow omega to overflow or wrap.
REQ-029 SHALL, on a cmd accepted while a tick occurs in RAMP, apply the step toward the old target this cycle and use the new target from the next tick.

Reset
REQ-030 SHALL on rst = 1 at a clk edge set state IDLE, omega 0, target 0, rate 1, prescaler 0, dwell counter 0.
REQ-031 SHALL give outputs after reset of cmd_ready 1 (if stop = 0), at_target 1, busy 0.
REQ-032 SHALL let rst override any in-progress ramp or dwell, and any simultaneous cmd or stop.

Structure
REQ-033 SHALL take the FSM state encoding and the OMEGA_BW default from the shared package sd_ctrl_pkg.
REQ-034 SHALL implement the prescaler as sub-module tick_prescaler (ports clk, rst, tick).

Verification
All scenarios use TICK_DIV=4, DWELL=3.
REQ-035 SHALL verify: reset, then cmd target=100 rate=10 -> omega rises by 10 every 4 clk; reaches 100 after 10 ticks; then HOLD, at_target=1, busy=0.
REQ-036 SHALL verify: from HOLD at 100, cmd target=-50 rate=30 -> omega 70, 40, 10, then 0; DWELL for 3 clk with cmd_ready=0; then -30, -50; then HOLD.
REQ-037 SHALL verify: cmd target=-32768 rate=255 -> omega ends at -32767 with no wrap.
REQ-038 SHALL verify: stop and cmd_valid asserted together at omega=60 rate=20 -> cmd not accepted; omega 40, 20, 0; then IDLE.
REQ-039 SHALL verify: rst pulsed mid-ramp at omega=50 -> next cycle omega=0, IDLE, prescaler restarts at 0.
REQ-040 SHALL verify: cmd target=3 rate=0 -> omega 1, 2, 3 on successive ticks; then HOLD.

Source files
------------

// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the speed-drive control blocks: ramp FSM state
// encoding and the default omega word width.
package sd_ctrl_pkg;

  localparam int OMEGA_BW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DWELL = 2'd2,
    ST_HOLD  = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick
// on the last count, then wraps.
module tick_prescaler #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // count register, wraps on the tick cycle
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/omega_ramp_ctrl.sv
// Omega ramp controller: slews a signed frequency word toward a commanded
// target at a fixed step per prescaler tick, dwelling at zero for a fixed
// number of clocks whenever the rotation direction reverses.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | omega at zero target, nothing to do
//   ST_RAMP  | stepping omega toward target on each tick
//   ST_DWELL | omega held at zero during a direction reversal
//   ST_HOLD  | omega parked on a nonzero target
module omega_ramp_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int OMEGA_BW = OMEGA_BW_DEFAULT,
  parameter int RATE_BW  = 8,
  parameter int TICK_DIV = 1024,
  parameter int DWELL    = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic signed [OMEGA_BW-1:0] cmd_target,
  input  logic        [RATE_BW-1:0]  cmd_rate,
  input  logic                       stop,
  output logic signed [OMEGA_BW-1:0] omega,
  output logic                       at_target,
  output logic                       busy
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Wide enough for target-omega and omega+/-rate without overflow.
  localparam int CW   = ((OMEGA_BW > RATE_BW) ? OMEGA_BW : RATE_BW) + 2;

  localparam logic signed [OMEGA_BW-1:0] OMEGA_NEG_LIM = {1'b1, {(OMEGA_BW-1){1'b0}}};
  localparam logic signed [OMEGA_BW-1:0] OMEGA_NEG_SAT = {1'b1, {(OMEGA_BW-2){1'b0}}, 1'b1};
  localparam logic [DW_W-1:0]            DWELL_LOAD    = DW_W'(DWELL - 1);
  localparam logic [RATE_BW-1:0]         RATE_ONE      = RATE_BW'(1);

  ramp_state_t                state, state_nx;
  logic signed [OMEGA_BW-1:0] omega_q, omega_nx;
  logic signed [OMEGA_BW-1:0] target_q, target_nx;
  logic        [RATE_BW-1:0]  rate_q, rate_nx;
  logic        [DW_W-1:0]     dwell_q, dwell_nx;

  logic                tick;
  logic                accept;
  logic signed [CW-1:0] om_x, tg_x, rate_x, d_x, abs_d, cand_x;
  logic                 in_reach;
  logic                 reverse;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign accept = cmd_valid && cmd_ready;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      omega_q  <= '0;
      target_q <= '0;
      rate_q   <= RATE_ONE;
      dwell_q  <= '0;
    end else begin
      state    <= state_nx;
      omega_q  <= omega_nx;
      target_q <= target_nx;
      rate_q   <= rate_nx;
      dwell_q  <= dwell_nx;
    end
  end

  // candidate ramp step and direction-reversal detection
  always_comb begin
    om_x   = {{(CW-OMEGA_BW){omega_q[OMEGA_BW-1]}}, omega_q};
    tg_x   = {{(CW-OMEGA_BW){target_q[OMEGA_BW-1]}}, target_q};
    rate_x = $signed({{(CW-RATE_BW){1'b0}}, rate_q});
    d_x    = tg_x - om_x;
    abs_d  = d_x[CW-1] ? -d_x : d_x;
    in_reach = (abs_d <= rate_x);
    if (in_reach)       cand_x = tg_x;
    else if (d_x[CW-1]) cand_x = om_x - rate_x;
    else                cand_x = om_x + rate_x;
    // A step that lands on or past zero while heading to the other side
    // must stop at zero and dwell before the direction flips.
    reverse = (omega_q != '0) && (target_q != '0) &&
              (omega_q[OMEGA_BW-1] != target_q[OMEGA_BW-1]) &&
              ((cand_x == '0) || (cand_x[CW-1] != omega_q[OMEGA_BW-1]));
  end

  // next-state and datapath update
  always_comb begin
    state_nx  = state;
    omega_nx  = omega_q;
    target_nx = target_q;
    rate_nx   = rate_q;
    dwell_nx  = dwell_q;

    case (state)
      ST_RAMP: begin
        if (tick) begin
          if (reverse) begin
            omega_nx = '0;
            state_nx = ST_DWELL;
            dwell_nx = DWELL_LOAD;
          end else if (in_reach) begin
            omega_nx = target_q;
            state_nx = (target_q == '0) ? ST_IDLE : ST_HOLD;
          end else begin
            omega_nx = cand_x[OMEGA_BW-1:0];
          end
        end
      end
      ST_DWELL: begin
        if (dwell_q == '0) state_nx = ST_RAMP;
        else               dwell_nx = dwell_q - 1'b1;
      end
      default: ;
    endcase

    // Stop and new commands act on top of this cycle's step, which still
    // uses the old target; a pending dwell is never cut short.
    if (stop) begin
      target_nx = '0;
      if (state_nx != ST_DWELL && omega_nx != '0) state_nx = ST_RAMP;
    end else if (accept) begin
      target_nx = (cmd_target == OMEGA_NEG_LIM) ? OMEGA_NEG_SAT : cmd_target;
      rate_nx   = (cmd_rate == '0) ? RATE_ONE : cmd_rate;
      if (state_nx != ST_DWELL) state_nx = ST_RAMP;
    end
  end

  // outputs decoded from registered state
  always_comb begin
    cmd_ready = !stop && (state != ST_DWELL);
    busy      = (state == ST_RAMP) || (state == ST_DWELL);
    at_target = (omega_q == target_q) && ((state == ST_IDLE) || (state == ST_HOLD));
    omega     = omega_q;
  end

endmodule

// File: tb/tb_omega_ramp_ctrl.sv
// Bench for omega_ramp_ctrl: a reference model turns each command into the
// list of omega values it should produce; a monitor pops them whenever the
// DUT omega changes and also checks tick alignment and dwell length.
module tb_omega_ramp_ctrl;

  localparam int TD = 4;
  localparam int DW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic signed [15:0] cmd_target = '0;
  logic        [7:0]  cmd_rate = '0;
  logic               stop = 1'b0;
  logic signed [15:0] omega;
  logic               at_target;
  logic               busy;

  always #5 clk = ~clk;

  omega_ramp_ctrl #(
    .OMEGA_BW (16),
    .RATE_BW  (8),
    .TICK_DIV (TD),
    .DWELL    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .stop       (stop),
    .omega      (omega),
    .at_target  (at_target),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int m_omega = 0;
  int m_rate = 1;
  int phase = 0;

  // clocks since reset, modulo the tick period
  always @(posedge clk) phase <= rst ? 0 : (phase + 1) % TD;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Sequence of omega values a ramp from m_omega to t at rate r visits.
  task automatic model_ramp(input int t_in, input int r_in);
    int t, r, w, d, cand;
    t = (t_in == -32768) ? -32767 : t_in;
    r = (r_in == 0) ? 1 : r_in;
    w = m_omega;
    while (w != t) begin
      d = t - w;
      if ((d < 0 ? -d : d) <= r) cand = t;
      else                       cand = (d > 0) ? w + r : w - r;
      if (((w > 0 && t < 0) || (w < 0 && t > 0)) &&
          ((w > 0 && cand <= 0) || (w < 0 && cand >= 0)))
        cand = 0;
      exp_q.push_back(cand);
      w = cand;
    end
    m_omega = t;
    m_rate  = r;
  endtask

  // monitor
  initial begin
    int prev;
    int now;
    int run;
    bit rst_prev;
    prev = 0;
    run = 0;
    rst_prev = 1'b1;
    forever begin
      @(negedge clk);
      now = int'(omega);
      if (rst_prev) begin
        if (!rst) chk("reset_omega", now, 0);
      end else if (now != prev) begin
        chk("tick_phase", phase, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL omega_unexpected: actual=%0d expected=%0d", now, prev);
        end else begin
          chk("omega_step", now, exp_q.pop_front());
        end
      end
      if (busy && !cmd_ready && !stop && !rst) run++;
      else if (run > 0) begin
        chk("dwell_len", run, DW);
        run = 0;
      end
      prev = now;
      rst_prev = rst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int t, input int r);
    step();
    chk("cmd_ready", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_target = 16'(t);
    cmd_rate   = 8'(r);
    model_ramp(t, r);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic settle(input string name);
    int bound;
    int n;
    bound = TD * (exp_q.size() + 4) + 20;
    n = 0;
    while (n < bound && !(exp_q.size() == 0 && !busy)) begin
      step();
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=%0d expected=<%0d", name, n, bound);
    end
    chk({name, "_omega"}, int'(omega), m_omega);
    chk({name, "_at_target"}, int'(at_target), 1);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic stop_ramp(input string name);
    step();
    stop = 1'b1;
    #1;
    chk({name, "_ready"}, int'(cmd_ready), 0);
    model_ramp(0, m_rate);
    settle(name);
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int r;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_omega", int'(omega), 0);

    send_cmd(100, 10);
    settle("up100");

    send_cmd(-50, 30);
    settle("rev_m50");

    send_cmd(-32768, 255);
    settle("neg_limit");

    send_cmd(60, 20);
    settle("to60");

    // stop wins over a simultaneous command
    step();
    stop = 1'b1;
    cmd_valid = 1'b1;
    cmd_target = 16'sd1000;
    cmd_rate = 8'd5;
    #1;
    chk("stop_cmd_ready", int'(cmd_ready), 0);
    model_ramp(0, m_rate);
    step();
    cmd_valid = 1'b0;
    settle("stop60");
    stop = 1'b0;

    // reset in the middle of a ramp
    send_cmd(500, 10);
    n = 0;
    while (n < 200 && int'(omega) != 50) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL mid_reset_wait: actual=%0d expected=50", int'(omega));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    m_omega = 0;
    m_rate = 1;
    chk("mid_rst_omega", int'(omega), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_at_target", int'(at_target), 1);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);

    send_cmd(3, 0);
    settle("rate0");

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        stop_ramp("rand_stop");
      end else begin
        t = int'($urandom_range(0, 3000)) - 1500;
        r = int'($urandom_range(4, 255));
        send_cmd(t, r);
        settle("rand_cmd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
